// File: rtl/uart_tx_path.sv
// rtl/uart_tx_path.sv - UART transmit path: TX FIFO, oversample baud tick and frame serialiser
module uart_tx_path #(
  parameter int DATA_BITS  = 8,
  parameter int PAR_TYP    = 0,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 54
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        tx_fifo_wr_en,
  input  logic [DATA_BITS-1:0]        tx_fifo_din,
  output logic                        tx_fifo_full,
  output logic                        tx_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_fifo_count,
  output logic                        tx_busy,
  output logic                        tx
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  // Any PAR_TYP other than 0 (even) or 1 (odd) means no parity bit.
  localparam bit HAS_PAR  = (PAR_TYP == 0) || (PAR_TYP == 1);
  localparam bit ODD_PAR  = (PAR_TYP == 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_next;
  logic                 push;
  logic                 pop;

  logic [BAUD_W-1:0]    baud_cnt;
  logic                 tick;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick_clr;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 bit_adv;

  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 parity_bit;
  logic                 tx_next;

  // A push is judged against the registered full flag, so a push that
  // coincides with a pop from a full FIFO is still dropped.
  assign push = tx_fifo_wr_en && !tx_fifo_full;

  // Occupancy after this cycle's push/pop; flags are registered from it.
  always_comb begin
    count_next = tx_fifo_count;
    unique case ({push, pop})
      2'b10:   count_next = tx_fifo_count + CNT_W'(1);
      2'b01:   count_next = tx_fifo_count - CNT_W'(1);
      default: count_next = tx_fifo_count;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_fifo_din;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_fifo_count <= '0;
      tx_fifo_empty <= 1'b1;
      tx_fifo_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      tx_fifo_count <= count_next;
      tx_fifo_empty <= (count_next == '0);
      tx_fifo_full  <= (count_next == CNT_FULL);
    end
  end

  // Oversample tick fires on the last PCLK of each BAUD_DIV period, only while a frame is active.
  assign tick = (state != S_IDLE) && (baud_cnt == BAUD_LAST);

  // Baud divider, parked at zero in IDLE so every frame starts phase-aligned.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

  // Tick counter within the current bit, restarted whenever a bit ends.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || tick_clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Serialiser state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a bit ends on the 16th tick, the stop bit after SB_TICK ticks.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tick_clr   = 1'b0;
    bit_adv    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!tx_fifo_empty) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: begin
        if (tick && tick_cnt == BIT_LAST) begin
          state_next = S_DATA;
          tick_clr   = 1'b1;
        end
      end
      S_DATA: begin
        if (tick && tick_cnt == BIT_LAST) begin
          tick_clr = 1'b1;
          bit_adv  = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            state_next = HAS_PAR ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick && tick_cnt == BIT_LAST) begin
          state_next = S_STOP;
          tick_clr   = 1'b1;
        end
      end
      S_STOP: begin
        if (tick && tick_cnt == STOP_LAST) begin
          state_next = S_IDLE;
          tick_clr   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Parity comes from the untouched copy of the popped byte, not the shifter.
  assign parity_bit = ODD_PAR ? ~^data_reg : ^data_reg;

  // Shifter update and the line level for the state being entered, so tx can be a flop.
  always_comb begin
    shift_next = shift_reg;
    if (pop) begin
      shift_next = mem[rd_ptr];
    end else if (bit_adv) begin
      shift_next = shift_reg >> 1;
    end
    tx_next = 1'b1;
    unique case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_bit;
      default:  tx_next = 1'b1;
    endcase
  end

  // Frame datapath: shift register, byte copy, bit index and the registered line.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      shift_reg <= '0;
      data_reg  <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
    end else begin
      shift_reg <= shift_next;
      tx        <= tx_next;
      if (pop) begin
        data_reg <= mem[rd_ptr];
        bit_cnt  <= '0;
      end else if (bit_adv) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_path.sv
// tb/tb_uart_tx_path.sv - scoreboard bench for uart_tx_path with line-decoding monitors
module tb_uart_tx_path;

  localparam int BIT_CYC = 64;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b0;
  logic [2:0] wr_en   = 3'b000;
  logic [7:0] din     = 8'h00;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] busy;
  logic [2:0] txl;
  logic [4:0] cnt [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  always #5 PCLK = ~PCLK;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp_push(int idx, logic [7:0] b);
    case (idx)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic exp_pop(int idx, output logic [7:0] b, output int ok);
    ok = 0;
    b  = 8'h00;
    case (idx)
      0:       if (q0.size() > 0) begin b = q0.pop_front(); ok = 1; end
      1:       if (q1.size() > 0) begin b = q1.pop_front(); ok = 1; end
      default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1; end
    endcase
  endtask

  // Instance 0: even parity, 1: odd parity, 2: no parity.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_path #(
      .DATA_BITS (8),
      .PAR_TYP   (g),
      .SB_TICK   (16),
      .FIFO_DEPTH(16),
      .BAUD_DIV  (4)
    ) u_dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .tx_fifo_wr_en(wr_en[g]),
      .tx_fifo_din  (din),
      .tx_fifo_full (full[g]),
      .tx_fifo_empty(empty[g]),
      .tx_fifo_count(cnt[g]),
      .tx_busy      (busy[g]),
      .tx           (txl[g])
    );

    // Decodes each frame from the line at mid-bit and checks it against the queue.
    initial begin : mon
      int c, bc, nb, par_on, elen, ok, pexp;
      logic [15:0] bits;
      logic [7:0]  eb;
      bit          in_frame;
      par_on   = (g < 2) ? 1 : 0;
      nb       = 10 + par_on;
      elen     = (16 * (9 + par_on) + 16) * 4;
      in_frame = 1'b0;
      c        = 0;
      bc       = 0;
      bits     = '0;
      forever begin
        @(negedge PCLK);
        if (!PRESETn) begin
          in_frame = 1'b0;
          bc       = 0;
        end else begin
          if (busy[g]) begin
            bc++;
          end else if (bc > 0) begin
            chk($sformatf("busy_len[%0d]", g), bc, elen);
            bc = 0;
          end
          if (!in_frame && !txl[g]) begin
            in_frame = 1'b1;
            c        = 0;
          end
          if (in_frame) begin
            if (c % BIT_CYC == BIT_CYC / 2) bits[c / BIT_CYC] = txl[g];
            if (c == BIT_CYC * (nb - 1) + BIT_CYC / 2) begin
              exp_pop(g, eb, ok);
              chk($sformatf("frame_expected[%0d]", g), ok, 1);
              if (ok == 1) begin
                pexp = $countones(eb) % 2;
                if (g == 1) pexp = 1 - pexp;
                chk($sformatf("start_bit[%0d]", g), int'(bits[0]), 0);
                chk($sformatf("data[%0d]", g), int'(bits[8:1]), int'(eb));
                if (par_on == 1) chk($sformatf("parity[%0d]", g), int'(bits[9]), pexp);
                chk($sformatf("stop_bit[%0d]", g), int'(bits[nb-1]), 1);
              end
              in_frame = 1'b0;
            end
            c++;
          end
        end
      end
    end
  end

  task automatic drive(logic [2:0] m, logic [7:0] b);
    wr_en = m;
    din   = b;
    @(posedge PCLK);
    #1;
    wr_en = 3'b000;
  endtask

  task automatic wait_busy(int val, int lim, string nm, output int n);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (int'(busy[0]) != val && n < lim);
    if (int'(busy[0]) != val) chk({"timeout_", nm}, int'(busy[0]), val);
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(busy == 3'b000 && empty == 3'b111) && n < 30000);
    chk({"idle_", nm}, int'(busy == 3'b000 && empty == 3'b111), 1);
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] rb [17];
    int         n;
    bit         done;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx[%0d]", i), int'(txl[i]), 1);
      chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("rst_count[%0d]", i), int'(cnt[i]), 0);
      chk($sformatf("rst_empty[%0d]", i), int'(empty[i]), 1);
      chk($sformatf("rst_full[%0d]", i), int'(full[i]), 0);
    end
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    // Single frame and push-to-start latency.
    drive(3'b001, 8'hA5);
    exp_push(0, 8'hA5);
    chk("t1_tx_high_after_push", int'(txl[0]), 1);
    chk("t1_count_after_push", int'(cnt[0]), 1);
    @(posedge PCLK);
    #1;
    chk("t1_tx_low", int'(txl[0]), 0);
    chk("t1_busy", int'(busy[0]), 1);
    chk("t1_count_after_pop", int'(cnt[0]), 0);
    wait_idle("t1");

    // Parity variants on all three instances.
    drive(3'b111, 8'h07);
    for (int i = 0; i < 3; i++) exp_push(i, 8'h07);
    b = 8'($urandom);
    drive(3'b111, b);
    for (int i = 0; i < 3; i++) exp_push(i, b);
    wait_idle("t4");

    // Back-to-back frames with a single idle cycle between them.
    drive(3'b001, 8'h01);
    exp_push(0, 8'h01);
    drive(3'b001, 8'h02);
    exp_push(0, 8'h02);
    drive(3'b001, 8'h03);
    exp_push(0, 8'h03);
    for (int k = 0; k < 2; k++) begin
      wait_busy(0, 800, "t3_fall", n);
      wait_busy(1, 10, "t3_rise", n);
      chk($sformatf("t3_gap%0d", k), n, 1);
    end
    chk("t3_empty", int'(empty[0]), 1);
    chk("t3_count", int'(cnt[0]), 0);
    wait_idle("t3");

    // Overflow while frame 1 is in flight.
    b = 8'($urandom);
    drive(3'b001, b);
    exp_push(0, b);
    @(posedge PCLK);
    #1;
    chk("t2_busy", int'(busy[0]), 1);
    for (int i = 0; i < 17; i++) begin
      rb[i] = 8'($urandom);
      drive(3'b001, rb[i]);
      if (i < 16) exp_push(0, rb[i]);
      if (i == 14) begin
        chk("t2_count15", int'(cnt[0]), 15);
        chk("t2_not_full15", int'(full[0]), 0);
      end
      if (i >= 15) begin
        chk($sformatf("t2_count16_%0d", i), int'(cnt[0]), 16);
        chk($sformatf("t2_full_%0d", i), int'(full[0]), 1);
      end
    end

    // Push on the pop cycle while full: dropped.
    wait_busy(0, 800, "t5a", n);
    wr_en = 3'b001;
    din   = 8'($urandom);
    @(posedge PCLK);
    #1;
    wr_en = 3'b000;
    chk("t5_full_pop_count", int'(cnt[0]), 15);
    chk("t5_full_pop_flag", int'(full[0]), 0);

    // Push on the pop cycle at count 5: accepted, count unchanged.
    done = 1'b0;
    for (int it = 0; it < 20 && !done; it++) begin
      wait_busy(0, 800, "t5b_fall", n);
      if (cnt[0] == 5'd5) begin
        b     = 8'($urandom);
        wr_en = 3'b001;
        din   = b;
        exp_push(0, b);
        @(posedge PCLK);
        #1;
        wr_en = 3'b000;
        chk("t5_count_hold", int'(cnt[0]), 5);
        done = 1'b1;
      end else begin
        wait_busy(1, 10, "t5b_rise", n);
      end
    end
    chk("t5_found_count5", int'(done), 1);
    wait_idle("t2");

    // Reset in the middle of the data bits.
    drive(3'b001, 8'($urandom));
    drive(3'b001, 8'($urandom));
    drive(3'b001, 8'($urandom));
    repeat (BIT_CYC * 3) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("t6_tx", int'(txl[0]), 1);
    chk("t6_busy", int'(busy[0]), 0);
    chk("t6_empty", int'(empty[0]), 1);
    chk("t6_count", int'(cnt[0]), 0);
    q0.delete();
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    drive(3'b001, 8'h3C);
    exp_push(0, 8'h3C);
    wait_idle("t6");

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
